// File: rtl/serial_deframer.sv
// serial_deframer: hunts for an 8-bit SYNC header in a strobed serial stream,
// then extracts DATA_W-bit payloads protected by one even-parity bit. Once a
// good frame is seen, the following header is checked in place; any parity or
// header failure drops alignment and restarts the sliding hunt.
module serial_deframer #(
  parameter logic [7:0] SYNC   = 8'hA5,
  parameter int         DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              sync_lost,
  output logic              locked
);

  // The counter indexes payload bits (0..DATA_W-1) and header bits (0..7),
  // so it needs at least 3 bits even for very narrow payloads.
  localparam int CNT_W = ($clog2(DATA_W + 1) > 3) ? $clog2(DATA_W + 1) : 3;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(7);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    PARITY,
    SYNC_CHK
  } state_t;

  state_t            state_reg;
  // Only the seven most recent bits are kept: the eighth comes straight from
  // `in` at compare time, so the oldest bit would never be looked at.
  logic [6:0]        window_reg;
  logic [DATA_W-1:0] payload_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [7:0]        window_next;
  logic [DATA_W-1:0] payload_next;
  logic              parity_ok;

  // Candidate header formed by the stored bits plus the bit being sampled now.
  assign window_next = {window_reg, in};

  // Payload shifted MSB first; built per bit so DATA_W=1 needs no special slice.
  assign payload_next[0] = in;
  generate
    for (genvar gi = 1; gi < DATA_W; gi++) begin : g_shift
      assign payload_next[gi] = payload_reg[gi-1];
    end
  endgenerate

  // Even parity: payload bits plus the parity bit must XOR to zero.
  assign parity_ok = ~(^{payload_reg, in});

  // Frame state machine; pulses default low so each lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= HUNT;
      window_reg  <= '0;
      payload_reg <= '0;
      cnt_reg     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      sync_lost   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      sync_lost  <= 1'b0;
      if (en) begin
        case (state_reg)
          HUNT: begin
            window_reg <= window_next[6:0];
            if (window_next == SYNC) begin
              state_reg <= DATA;
              cnt_reg   <= '0;
            end
          end
          DATA: begin
            payload_reg <= payload_next;
            cnt_reg     <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_DATA) begin
              state_reg <= PARITY;
            end
          end
          PARITY: begin
            cnt_reg <= '0;
            if (parity_ok) begin
              data_out   <= payload_reg;
              data_valid <= 1'b1;
              locked     <= 1'b1;
              state_reg  <= SYNC_CHK;
            end else begin
              parity_err <= 1'b1;
              locked     <= 1'b0;
              window_reg <= '0;
              state_reg  <= HUNT;
            end
          end
          SYNC_CHK: begin
            window_reg <= window_next[6:0];
            cnt_reg    <= cnt_reg + 1'b1;
            // No early abort: the header is judged only once all 8 bits are in.
            if (cnt_reg == LAST_SYNC) begin
              cnt_reg <= '0;
              if (window_next == SYNC) begin
                state_reg <= DATA;
              end else begin
                sync_lost  <= 1'b1;
                locked     <= 1'b0;
                window_reg <= '0;
                state_reg  <= HUNT;
              end
            end
          end
          default: begin
            state_reg <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_deframer.sv
// tb_serial_deframer: directed and random bit streams for serial_deframer.
// Expected outputs come from a stream parser that walks the list of strobed
// bits by index (find header, take payload, check parity, check next header).
module tb_serial_deframer;

  localparam int         DW   = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXB = 1200;

  logic          clk;
  logic          rst;
  logic          en;
  logic          in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          sync_lost;
  logic          locked;

  serial_deframer #(.SYNC(SYNC), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .sync_lost (sync_lost),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Stream under test and the per-bit expectations derived from it.
  bit            sbits [0:MAXB+63];
  int            n_bits;
  int            ev    [0:MAXB+63];   // 0 none, 1 valid, 2 parity error, 3 sync lost
  logic [DW-1:0] edata [0:MAXB+63];
  bit            elk   [0:MAXB+63];

  logic [DW-1:0] cur_d;
  bit            cur_lk;
  int            n_valid;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input logic [15:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      if (n_bits < MAXB) begin
        sbits[n_bits] = v[i];
        n_bits++;
      end
    end
  endtask

  // Header, payload and parity bit; bad_par flips the parity bit.
  task automatic push_frame(input logic [7:0] hdr, input logic [DW-1:0] pay, input bit bad_par);
    push_bits({8'h00, hdr}, 8);
    push_bits({{(16-DW){1'b0}}, pay}, DW);
    push_bits({15'd0, (^pay) ^ bad_par}, 1);
  endtask

  task automatic mark(input int k, input int e, input logic [DW-1:0] d, input bit lk);
    ev[k]    = e;
    edata[k] = d;
    elk[k]   = lk;
  endtask

  // Reference parser over the bit list: outcomes are attached to the index of
  // the strobed bit that decides them.
  task automatic build_model();
    int            k;
    logic [7:0]    win;
    logic [7:0]    hdr;
    logic [DW-1:0] pay;
    logic [DW-1:0] d;
    bit            lk;
    bit            stay;
    for (int i = n_bits; i < MAXB + 64; i++) sbits[i] = 1'b0;
    k  = 0;
    d  = cur_d;
    lk = cur_lk;
    while (k < n_bits) begin
      win  = 8'h00;
      stay = 1'b0;
      while (k < n_bits && !stay) begin
        win = {win[6:0], sbits[k]};
        mark(k, 0, d, lk);
        if (win == SYNC) stay = 1'b1;
        k++;
      end
      while (stay && k < n_bits) begin
        pay = '0;
        for (int j = 0; j < DW; j++) begin
          pay = {pay[DW-2:0], sbits[k]};
          mark(k, 0, d, lk);
          k++;
        end
        if (((^pay) ^ sbits[k]) == 1'b0) begin
          d  = pay;
          lk = 1'b1;
          mark(k, 1, d, lk);
          k++;
          hdr = 8'h00;
          for (int j = 0; j < 8; j++) begin
            hdr = {hdr[6:0], sbits[k]};
            if (j < 7) mark(k, 0, d, lk);
            k++;
          end
          if (hdr != SYNC) begin
            lk = 1'b0;
            mark(k - 1, 3, d, lk);
            stay = 1'b0;
          end else begin
            mark(k - 1, 0, d, lk);
          end
        end else begin
          lk = 1'b0;
          mark(k, 2, d, lk);
          k++;
          stay = 1'b0;
        end
      end
    end
  endtask

  // Drives the stream with en patterns (0: every cycle, 1: alternate, 2: random)
  // and checks every cycle, including idle ones, against the parser.
  task automatic run_stream(input string name, input int gap_mode);
    int       k;
    int       c;
    bit       e;
    logic [2:0] exp_p;
    build_model();
    k = 0;
    c = 0;
    while (k < n_bits) begin
      @(negedge clk);
      case (gap_mode)
        0:       e = 1'b1;
        1:       e = (c % 2) == 1;
        default: e = $urandom_range(0, 2) != 0;
      endcase
      c++;
      en = e;
      in = e ? sbits[k] : 1'($urandom);
      @(posedge clk);
      #1;
      exp_p = 3'b000;
      if (e) begin
        case (ev[k])
          1:       exp_p = 3'b100;
          2:       exp_p = 3'b010;
          3:       exp_p = 3'b001;
          default: exp_p = 3'b000;
        endcase
        cur_d  = edata[k];
        cur_lk = elk[k];
        if (ev[k] == 1) n_valid++;
        k++;
      end
      chk({name, "_pulses"}, {13'd0, data_valid, parity_err, sync_lost}, {13'd0, exp_p});
      chk({name, "_data"}, {{(16-DW){1'b0}}, data_out}, {{(16-DW){1'b0}}, cur_d});
      chk({name, "_locked"}, {15'd0, locked}, {15'd0, cur_lk});
    end
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_idle_pulses"}, {13'd0, data_valid, parity_err, sync_lost}, 16'd0);
  endtask

  // Two reset cycles with en held high: nothing may pulse, everything clears.
  task automatic do_reset(input string name);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b1;
      in  = 1'($urandom);
      @(posedge clk);
      #1;
      chk({name, "_rst_pulses"}, {13'd0, data_valid, parity_err, sync_lost}, 16'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    chk({name, "_rst_data"}, {{(16-DW){1'b0}}, data_out}, 16'd0);
    chk({name, "_rst_locked"}, {15'd0, locked}, 16'd0);
    cur_d   = '0;
    cur_lk  = 1'b0;
    n_valid = 0;
    n_bits  = 0;
  endtask

  task automatic gen_random(input int segs);
    n_bits = 0;
    repeat (segs) begin
      case ($urandom_range(0, 5))
        0:       push_bits(16'($urandom), $urandom_range(1, 5));
        1, 2:    push_frame(SYNC, DW'($urandom), 1'b0);
        3:       push_frame(SYNC, DW'($urandom), 1'b1);
        4:       push_frame(8'($urandom), DW'($urandom), 1'b0);
        default: push_frame(SYNC, DW'($urandom), $urandom_range(0, 3) == 0);
      endcase
    end
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    in  = 1'b0;

    // Good frame, en every cycle.
    do_reset("good");
    push_frame(SYNC, 8'h3C, 1'b0);
    run_stream("good", 0);
    chk("good_final_data", {8'd0, data_out}, 16'h003C);
    chk("good_final_locked", {15'd0, locked}, 16'd1);

    // Parity error keeps the old data, then recovery.
    do_reset("perr");
    push_frame(SYNC, 8'h3C, 1'b1);
    push_frame(SYNC, 8'h81, 1'b0);
    run_stream("perr", 0);
    chk("perr_final_data", {8'd0, data_out}, 16'h0081);

    // Header mismatch after a good frame, then recovery.
    do_reset("slost");
    push_frame(SYNC, 8'h3C, 1'b0);
    push_bits(16'h00FF, 8);
    push_frame(SYNC, 8'h55, 1'b0);
    run_stream("slost", 0);
    chk("slost_final_data", {8'd0, data_out}, 16'h0055);

    // Leading garbage before the header.
    do_reset("garb");
    push_bits(16'h0005, 3);
    push_frame(SYNC, 8'hF0, 1'b0);
    run_stream("garb", 0);
    chk("garb_final_data", {8'd0, data_out}, 16'h00F0);
    chk("garb_valid_count", 16'(n_valid), 16'd1);

    // Alternate-cycle strobe.
    do_reset("alt");
    push_frame(SYNC, 8'h3C, 1'b0);
    run_stream("alt", 1);
    chk("alt_final_data", {8'd0, data_out}, 16'h003C);
    chk("alt_valid_count", 16'(n_valid), 16'd1);

    // Reset mid-payload, then a clean frame.
    do_reset("midrst");
    push_bits(16'h00A5, 8);
    push_bits(16'h0003, 4);
    run_stream("midrst_a", 0);
    do_reset("midrst");
    push_frame(SYNC, 8'hC3, 1'b0);
    run_stream("midrst_b", 2);
    chk("midrst_final_data", {8'd0, data_out}, 16'h00C3);

    // Random mixes of frames, bad frames, garbage and foreign headers.
    for (int r = 0; r < 6; r++) begin
      do_reset("rand");
      gen_random(40);
      run_stream("rand", (r % 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_deframer.md
SERIAL_DEFRAMER -- requirements
Module: serial_deframer

Interface
REQ-001 Parameter SYNC, default 8'hA5, SHALL be the 8-bit frame header pattern, received MSB first.
REQ-002 Parameter DATA_W, default 8, range 1..16, SHALL be the payload width in bits, received MSB first.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 en  input  1  SHALL be the bit strobe; `in` is sampled only on cycles with en=1.
REQ-006 in  input  1  SHALL be the serial bit stream from the upstream shift register.
REQ-007 data_out  output  DATA_W  SHALL be the last payload that passed the parity check; registered.
REQ-008 data_valid  output  1  SHALL be a one-cycle pulse marking a new data_out.
REQ-009 parity_err  output  1  SHALL be a one-cycle pulse marking a frame that failed parity.
REQ-010 sync_lost  output  1  SHALL be a one-cycle pulse marking a mismatched header while locked.
REQ-011 locked  output  1  SHALL be a level, high while frame alignment is held.

Function
REQ-012 The frame SHALL be: 8 SYNC bits, then DATA_W payload bits, then 1 parity bit (even parity over payload plus parity bit).
REQ-013 The FSM SHALL have states HUNT, DATA, PARITY, SYNC_CHK; cycles with en=0 SHALL change no state, counter or register.
REQ-014 HUNT: each en cycle SHALL shift `in` into an 8-bit window; when {window[6:0],in}==SYNC the FSM SHALL go to DATA with bit counter 0.
REQ-015 HUNT detection SHALL be sliding (any bit alignment); the window SHALL NOT be cleared on a failed compare.
REQ-016 DATA: each en cycle SHALL shift `in` into the payload register and increment the counter; after the DATA_W-th bit the FSM SHALL go to PARITY.
REQ-017 PARITY, en=1, parity good: data_out <= payload, data_valid=1 on the next cycle, locked <= 1, FSM -> SYNC_CHK, counter 0.
REQ-018 PARITY, en=1, parity bad: parity_err=1 on the next cycle, data_out unchanged, locked <= 0, window cleared to 0, FSM -> HUNT.
REQ-019 SYNC_CHK: 8 en bits SHALL be collected; on the 8th, a match with SYNC -> DATA; a mismatch -> sync_lost=1 on the next cycle, locked <= 0, window cleared, FSM -> HUNT.
REQ-020 SYNC_CHK SHALL compare only on the 8th bit, with no early abort.
REQ-021 Pulse outputs SHALL be high for exactly one clk cycle; pulses and locked SHALL be registered (latency 1 cycle after the sampling en edge).
REQ-022 At most one of data_valid, parity_err, sync_lost SHALL be high in any cycle.
REQ-023 locked SHALL stay high through DATA/PARITY/SYNC_CHK of subsequent frames until a parity error, a header mismatch or reset.
REQ-024 Internal counter width SHALL be ceil(log2(DATA_W+1)) minimum; no wrap SHALL occur within a frame.

Reset
REQ-025 rst=1 at a rising edge SHALL set: FSM=HUNT; window, payload, counter=0; data_out=0; data_valid, parity_err, sync_lost, locked=0.
REQ-026 rst SHALL take priority over en in the same cycle; a reset mid-frame SHALL discard the partial frame with no pulse.
REQ-027 After rst deasserts, the first en cycle SHALL be treated as HUNT bit 0.

Verification
REQ-028 Bits A5,3C, parity 0, en=1 every cycle -> data_out=8'h3C, data_valid one cycle after the parity bit, locked=1.
REQ-029 Bits A5,3C, parity 1 -> parity_err pulse, data_out keeps its prior value (0 after reset), locked=0, next A5,81,0 frame accepted (data_out=8'h81).
REQ-030 Good frame A5,3C,0, then header 8'hFF -> sync_lost pulse one cycle after the 8th header bit, locked=0; the following A5,55,0 gives data_out=8'h55.
REQ-031 Leading garbage 1,0,1 then A5,F0,0 -> sliding hunt locks; data_out=8'hF0; no false match on the garbage.
REQ-032 Frame A5,3C,0 with en=1 only on alternate cycles -> same result as REQ-028, data_valid a single cycle wide.
REQ-033 rst asserted after 4 payload bits of A5,3C,0, then a full A5,C3,0 -> no pulse during reset; data_out=8'hC3 after the clean frame.
